// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: sequencer for ARM-style LDM/STM block transfers.
// One register moves per cycle, lowest-numbered register first, at ascending
// addresses. An optional base-register writeback cycle follows, then a
// single-cycle done pulse.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   start                request a transfer (only looked at in IDLE)
//   is_load              1 = LDM (mem -> rf), 0 = STM (rf -> mem)
//   pre, up, wback       P, U, W instruction bits
//   rn_idx, base         base register number and its value
//   reg_list             bit i selects register i
//   rf_ARs / rf_Rs       register-file read port (STM data)
//   rf_ARd/rf_wen/rf_wdata  register-file write port
//   mem_addr/mem_wen/mem_ren/mem_wdata/mem_rdata  data memory, combinational read
//   busy, done           busy in XFER/WBACK; done pulses for one cycle
//
// The strobes and addresses are decoded from registered state. The data paths
// rf_Rs -> mem_wdata and mem_rdata -> rf_wdata go straight through, so each
// register moves in the same cycle its address is presented.
module ldm_stm_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        pre,
  input  logic        up,
  input  logic        wback,
  input  logic [3:0]  rn_idx,
  input  logic [31:0] base,
  input  logic [15:0] reg_list,
  output logic [3:0]  rf_ARs,
  input  logic [31:0] rf_Rs,
  output logic [3:0]  rf_ARd,
  output logic        rf_wen,
  output logic [31:0] rf_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_WBACK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [LW-1:0]   r_list;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_new_base;
  logic [IW-1:0]   r_rn_idx;
  logic            r_is_load;
  logic            r_do_wb;

  logic [CW-1:0]   w_cnt;
  logic [AW-1:0]   w_span;
  logic [AW-1:0]   w_start_addr;
  logic [AW-1:0]   w_new_base;
  logic            w_wb_ok;
  logic [IW-1:0]   w_idx;
  logic            w_last;

  // Popcount of the incoming list and the 4N byte span it covers.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < int'(LW); i++) begin
      w_cnt = w_cnt + CW'(reg_list[i]);
    end
    w_span = AW'(w_cnt) << 2;
  end

  // Lowest transfer address from P/U; all arithmetic wraps mod 2^32.
  always_comb begin
    unique case ({pre, up})
      2'b01:   w_start_addr = base;
      2'b11:   w_start_addr = base + AW'(4);
      2'b00:   w_start_addr = base - w_span + AW'(4);
      default: w_start_addr = base - w_span;
    endcase
    w_new_base = up ? (base + w_span) : (base - w_span);
    // A load that includes the base register keeps the loaded value.
    w_wb_ok    = wback && !(is_load && reg_list[rn_idx]);
  end

  // Lowest set bit of the remaining list; descending scan so the lowest wins.
  always_comb begin
    w_idx = '0;
    for (int i = int'(LW) - 1; i >= 0; i--) begin
      if (r_list[i]) w_idx = IW'(i);
    end
    w_last = (r_list & (r_list - LW'(1))) == '0;
  end

  // State and operation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_list     <= '0;
      r_addr     <= '0;
      r_new_base <= '0;
      r_rn_idx   <= '0;
      r_is_load  <= 1'b0;
      r_do_wb    <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_list     <= reg_list;
            r_addr     <= w_start_addr;
            r_new_base <= w_new_base;
            r_rn_idx   <= rn_idx;
            r_is_load  <= is_load;
            r_do_wb    <= w_wb_ok;
          end
        end
        S_XFER: begin
          // Clearing the lowest set bit retires the register just moved.
          r_list <= r_list & (r_list - LW'(1));
          r_addr <= r_addr + AW'(4);
        end
        default: ;
      endcase
    end
  end

  // Next state and output decode.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_wdata = '0;
    rf_ARs    = '0;
    rf_ARd    = '0;
    rf_wen    = 1'b0;
    rf_wdata  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = (reg_list == '0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        busy     = 1'b1;
        mem_addr = r_addr;
        if (r_is_load) begin
          mem_ren  = 1'b1;
          rf_ARd   = w_idx;
          rf_wdata = mem_rdata;
          rf_wen   = 1'b1;
        end else begin
          rf_ARs    = w_idx;
          mem_wdata = rf_Rs;
          mem_wen   = 1'b1;
        end
        if (w_last) w_next = r_do_wb ? S_WBACK : S_DONE;
      end
      S_WBACK: begin
        busy     = 1'b1;
        rf_ARd   = r_rn_idx;
        rf_wdata = r_new_base;
        rf_wen   = 1'b1;
        w_next   = S_DONE;
      end
      default: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq: directed bench for ldm_stm_seq.
// Register file reads return 0x1000_0000 | index; memory reads return
// address ^ 0xA5A5_0000, so every expected data word is a hand-known constant.
// Expected strobe vector is {busy, done, mem_wen, mem_ren, rf_wen}.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        pre;
  logic        up;
  logic        wback;
  logic [3:0]  rn_idx;
  logic [31:0] base;
  logic [15:0] reg_list;
  logic [3:0]  rf_ARs;
  logic [31:0] rf_Rs;
  logic [3:0]  rf_ARd;
  logic        rf_wen;
  logic [31:0] rf_wdata;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  ldm_stm_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_load   (is_load),
    .pre       (pre),
    .up        (up),
    .wback     (wback),
    .rn_idx    (rn_idx),
    .base      (base),
    .reg_list  (reg_list),
    .rf_ARs    (rf_ARs),
    .rf_Rs     (rf_Rs),
    .rf_ARd    (rf_ARd),
    .rf_wen    (rf_wen),
    .rf_wdata  (rf_wdata),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign rf_Rs     = 32'h1000_0000 | 32'(rf_ARs);
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Check one cycle: strobes always, then the fields the strobes make meaningful.
  task automatic chk_cyc(input string tag, input logic [4:0] strb,
                         input logic [31:0] addr, input logic [3:0] a,
                         input logic [31:0] d);
    chk({tag, ".strb"}, 32'({busy, done, mem_wen, mem_ren, rf_wen}), 32'(strb));
    if (strb[2] | strb[1]) chk({tag, ".addr"}, mem_addr, addr);
    if (strb[2]) begin
      chk({tag, ".ARs"}, 32'(rf_ARs), 32'(a));
      chk({tag, ".mwdata"}, mem_wdata, d);
    end
    if (strb[0]) begin
      chk({tag, ".ARd"}, 32'(rf_ARd), 32'(a));
      chk({tag, ".rfwdata"}, rf_wdata, d);
    end
    if (strb == 5'b0) begin
      chk({tag, ".idle_addr"}, mem_addr, 32'h0);
      chk({tag, ".idle_ars"}, 32'(rf_ARs), 32'h0);
      chk({tag, ".idle_ard"}, 32'(rf_ARd), 32'h0);
      chk({tag, ".idle_mwd"}, mem_wdata, 32'h0);
      chk({tag, ".idle_rfwd"}, rf_wdata, 32'h0);
    end
  endtask

  // Issue start at edge T; return at the middle of cycle T+1 with start still
  // high and all operands scrambled, so the next edge tests both ignore rules.
  task automatic launch(input logic ld, input logic p, input logic u,
                        input logic wb, input logic [3:0] rn,
                        input logic [31:0] b, input logic [15:0] lst);
    @(negedge clk);
    is_load = ld; pre = p; up = u; wback = wb;
    rn_idx = rn; base = b; reg_list = lst; start = 1'b1;
    @(negedge clk);
    is_load = ~ld; pre = ~p; up = ~u; wback = ~wb;
    rn_idx = ~rn; base = 32'hDEAD_BEEF; reg_list = 16'hFFFF;
  endtask

  task automatic nxt();
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with start held high: reset wins.
    rst = 1'b1; start = 1'b1; is_load = 1'b0; pre = 1'b0; up = 1'b1;
    wback = 1'b1; rn_idx = 4'd0; base = 32'h100; reg_list = 16'h0003;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cyc("reset", 5'b00000, 32'h0, 4'h0, 32'h0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk_cyc("post_reset", 5'b00000, 32'h0, 4'h0, 32'h0);

    // STM IA with writeback.
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h0013);
    chk_cyc("stm_ia.c1", 5'b10100, 32'h100, 4'd0, 32'h1000_0000);
    nxt(); chk_cyc("stm_ia.c2", 5'b10100, 32'h104, 4'd1, 32'h1000_0001);
    nxt(); chk_cyc("stm_ia.c3", 5'b10100, 32'h108, 4'd4, 32'h1000_0004);
    nxt(); chk_cyc("stm_ia.wb", 5'b10001, 32'h0, 4'd13, 32'h0000_010C);
    nxt(); chk_cyc("stm_ia.done", 5'b01000, 32'h0, 4'd0, 32'h0);
    nxt(); chk_cyc("stm_ia.idle", 5'b00000, 32'h0, 4'd0, 32'h0);

    // LDM DB, no writeback, r15 loaded like any other register.
    launch(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h40, 16'h8002);
    chk_cyc("ldm_db.c1", 5'b10011, 32'h38, 4'd1, 32'hA5A5_0038);
    nxt(); chk_cyc("ldm_db.c2", 5'b10011, 32'h3C, 4'd15, 32'hA5A5_003C);
    nxt(); chk_cyc("ldm_db.done", 5'b01000, 32'h0, 4'd0, 32'h0);
    nxt(); chk_cyc("ldm_db.idle", 5'b00000, 32'h0, 4'd0, 32'h0);

    // LDM IB with base in list: writeback suppressed.
    launch(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h20, 16'h0006);
    chk_cyc("ldm_ib.c1", 5'b10011, 32'h24, 4'd1, 32'hA5A5_0024);
    nxt(); chk_cyc("ldm_ib.c2", 5'b10011, 32'h28, 4'd2, 32'hA5A5_0028);
    nxt(); chk_cyc("ldm_ib.done", 5'b01000, 32'h0, 4'd0, 32'h0);
    nxt(); chk_cyc("ldm_ib.idle", 5'b00000, 32'h0, 4'd0, 32'h0);

    // Empty list: straight to DONE, no strobes.
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h500, 16'h0000);
    chk_cyc("empty.done", 5'b01000, 32'h0, 4'd0, 32'h0);
    nxt(); chk_cyc("empty.idle", 5'b00000, 32'h0, 4'd0, 32'h0);

    // STM DA across address zero with writeback.
    launch(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h4, 16'h0007);
    chk_cyc("wrap.c1", 5'b10100, 32'hFFFF_FFFC, 4'd0, 32'h1000_0000);
    nxt(); chk_cyc("wrap.c2", 5'b10100, 32'h0, 4'd1, 32'h1000_0001);
    nxt(); chk_cyc("wrap.c3", 5'b10100, 32'h4, 4'd2, 32'h1000_0002);
    nxt(); chk_cyc("wrap.wb", 5'b10001, 32'h0, 4'd3, 32'hFFFF_FFF8);
    nxt(); chk_cyc("wrap.done", 5'b01000, 32'h0, 4'd0, 32'h0);

    // Reset during the second XFER cycle of a 4-register STM.
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 32'h200, 16'h000F);
    chk_cyc("rstmid.c1", 5'b10100, 32'h200, 4'd0, 32'h1000_0000);
    nxt(); chk_cyc("rstmid.c2", 5'b10100, 32'h204, 4'd1, 32'h1000_0001);
    rst = 1'b1;
    nxt(); rst = 1'b0;
    chk_cyc("rstmid.after", 5'b00000, 32'h0, 4'd0, 32'h0);
    nxt(); chk_cyc("rstmid.q1", 5'b00000, 32'h0, 4'd0, 32'h0);
    nxt(); chk_cyc("rstmid.q2", 5'b00000, 32'h0, 4'd0, 32'h0);
    nxt(); chk_cyc("rstmid.q3", 5'b00000, 32'h0, 4'd0, 32'h0);

    // New operation accepted after the mid-op reset.
    launch(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h300, 16'h0001);
    chk_cyc("restart.c1", 5'b10100, 32'h300, 4'd0, 32'h1000_0000);
    nxt(); chk_cyc("restart.done", 5'b01000, 32'h0, 4'd0, 32'h0);
    nxt(); chk_cyc("restart.idle", 5'b00000, 32'h0, 4'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 The module SHALL have these ports: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 start, input, 1: request a block transfer; sampled only in IDLE.
REQ-004 is_load, input, 1: 1 = LDM (memory to register file), 0 = STM (register file to memory).
REQ-005 pre, up, wback, inputs, 1 each: P, U and W instruction bits.
REQ-006 rn_idx, input, 4: base register number; base, input, 32: base register value.
REQ-007 reg_list, input, 16: register list; bit i selects register i.
REQ-008 rf_ARs, output, 4, and rf_Rs, input, 32: register-file read port used for STM data.
REQ-009 rf_ARd, rf_wen and rf_wdata, outputs, 4, 1 and 32: register-file write port.
REQ-010 mem_addr, mem_wen and mem_ren, outputs, 32, 1 and 1; mem_wdata, output, 32; mem_rdata, input, 32: data memory with combinational read.
REQ-011 busy, output, 1: transfer in progress; done, output, 1: single-cycle completion pulse.

Function
REQ-012 The FSM SHALL have four states: IDLE, XFER, WBACK, DONE.
REQ-013 On start=1 in IDLE, the block SHALL latch reg_list, is_load, up, wback, rn_idx and base, and compute N = popcount(reg_list).
REQ-014 The start address SHALL be: P=0,U=1 -> base; P=1,U=1 -> base+4; P=0,U=0 -> base-4N+4; P=1,U=0 -> base-4N.
REQ-015 The new base SHALL be base+4N when U=1 and base-4N when U=0; all arithmetic is 32-bit modulo 2^32 with wrap-around and no flag.
REQ-016 If start=1 and reg_list=0, the FSM SHALL go IDLE->DONE with no memory or register-file strobes.
REQ-017 If start=1 and reg_list!=0, the FSM SHALL go IDLE->XFER.
REQ-018 In XFER, each cycle transfers exactly one register, idx = lowest set bit of the remaining list; registers go in ascending order at ascending addresses.
REQ-019 STM cycle: rf_ARs=idx, mem_addr=current address, mem_wdata=rf_Rs, mem_wen=1, mem_ren=0, rf_wen=0.
REQ-020 LDM cycle: mem_addr=current address, mem_ren=1, rf_ARd=idx, rf_wdata=mem_rdata, rf_wen=1, mem_wen=0.
REQ-021 After each XFER cycle, bit idx SHALL be cleared and the current address incremented by 4.
REQ-022 On the last XFER cycle, the FSM SHALL go to WBACK if wback=1 and not (LDM with bit rn_idx set); otherwise it goes to DONE.
REQ-023 WBACK SHALL last one cycle with rf_ARd=rn_idx, rf_wdata=new base, rf_wen=1, then go to DONE.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in XFER and WBACK and 0 in IDLE and DONE.
REQ-026 Latency: start at edge T gives transfers in cycles T+1..T+N, WBACK (if any) at T+N+1, and done at T+N+1 (no writeback) or T+N+2.
REQ-027 start SHALL be ignored outside IDLE, and latched inputs SHALL NOT be affected by changes on the input ports during an operation.
REQ-028 Register 15 in an LDM list SHALL be written like any other register; the register file owns PC semantics.
REQ-029 Strobes mem_wen, mem_ren and rf_wen SHALL never assert outside XFER/WBACK, and mem_wen and mem_ren SHALL never be high together.

Reset
REQ-030 rst=1 SHALL force IDLE at the next edge, including mid-XFER or mid-WBACK, and clear the latched list and address.
REQ-031 In reset and IDLE, busy, done, mem_wen, mem_ren and rf_wen SHALL be 0, and rf_ARd, rf_ARs, mem_addr, mem_wdata and rf_wdata SHALL be 0.
REQ-032 rst SHALL take priority over start in the same cycle.

Verification
REQ-033 STM IA with writeback: base=0x100, rn_idx=13, list=0x0013 (r0,r1,r4) -> writes to 0x100, 0x104 and 0x108 of r0, r1 and r4 on cycles T+1..T+3, then r13 <- 0x10C at T+4, done at T+5.
REQ-034 LDM DB, no writeback: base=0x40, list=0x8002 (r1,r15) -> r1 <- mem[0x38] and r15 <- mem[0x3C], done at T+3, no WBACK.
REQ-035 LDM IB with wback=1 and rn_idx=2 in the list: base=0x20, list=0x0006 -> r1 <- mem[0x24], r2 <- mem[0x28], no writeback cycle, done at T+3.
REQ-036 Empty list: start with reg_list=0 -> done at T+1, busy never high, no strobes.
REQ-037 Wrap-around: STM DA, base=0x4, list=0x0007, wback=1 -> addresses 0xFFFFFFFC, 0x0 and 0x4, then new base 0xFFFFFFF8.
REQ-038 Reset mid-op: rst asserted on the second XFER cycle of a 4-register STM -> IDLE next edge, no further mem_wen, no done pulse, and a new start is accepted afterwards.
